btn_conditioner: RTL



---
 rtl/pacman_pkg.sv | 24 ++
 rtl/btn_conditioner_if.sv | 26 ++
 rtl/debounce_bit.sv | 50 +++++
 rtl/btn_conditioner.sv | 58 +++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared direction encoding for the player front end and the movement block.
// Latency: none (constants and a pure function).
// Backpressure: none; consumers sample the one-hot encoding every clock.
//
// Contents: DIR_L/U/R/D one-hot constants (bit 3..0) and prio_pick(), which
// returns the highest-priority set bit of a request vector (L > U > R > D).
package pacman_pkg;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  function automatic logic [3:0] prio_pick(input logic [3:0] req);
    logic [3:0] pick;
    pick = 4'b0000;
    if (req[3])      pick = DIR_L;
    else if (req[2]) pick = DIR_U;
    else if (req[1]) pick = DIR_R;
    else if (req[0]) pick = DIR_D;
    return pick;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Bundle between the raw push-buttons and the conditioned direction request.
// Latency: wiring only.
// Backpressure: none; btn/press_evt are level/pulse outputs sampled every clock.
//
// Signals: btn_raw[3:0] raw buttons (L,U,R,D), btn[3:0] one-hot or zero
// direction request, press_evt[3:0] one-cycle pulse per accepted press.
// master = button side (drives btn_raw), slave = the conditioner.
interface btn_conditioner_if;

  logic [3:0] btn_raw;
  logic [3:0] btn;
  logic [3:0] press_evt;

  modport master (
    output btn_raw,
    input  btn,
    input  press_evt
  );

  modport slave (
    input  btn_raw,
    output btn,
    output press_evt
  );

endinterface

// File: rtl/debounce_bit.sv
// One button: two-flop synchronizer, debounce counter, debounced level, rise pulse.
// Latency: debounced level and rise pulse appear DEBOUNCE_CYCLES+1 edges after sync1 samples.
// Backpressure: none; free-running every clock.
//
// Ports: clk, rst (sync, active-high), raw (async input), s (debounced level),
// rise (registered one-cycle pulse when s goes 0->1).
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic s,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample agreeing with the current level restarts the count, so a
      // new level is only accepted after an unbroken run; cnt never wraps
      // because it is cleared on acceptance.
      if (sync2 == s) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        s    <= sync2;
        cnt  <= '0;
        rise <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions four raw direction buttons into a one-hot (or zero) direction request.
// Latency: press_evt at sync1-sample + DEBOUNCE_CYCLES + 1 edges, btn one edge later.
// Backpressure: none; outputs are refreshed every clock for the movement block.
//
// Ports: clk, rst (sync, active-high), bus (btn_conditioner_if.slave:
// btn_raw in, btn out, press_evt out). Bit order L,U,R,D = 3..0.
module btn_conditioner
  import pacman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_conditioner_if.slave     bus
);

  logic [3:0] s;
  logic [3:0] rise;
  logic [3:0] btn_q;
  logic [3:0] btn_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_raw[i]),
      .s   (s[i]),
      .rise(rise[i])
    );
  end

  // Arbiter: a fresh press always takes over; otherwise, once the selected
  // button has been released, fall back to whatever is still held.
  always_comb begin
    btn_nxt = btn_q;
    if (rise != 4'b0000) begin
      btn_nxt = prio_pick(rise);
    end else if ((btn_q != 4'b0000) && ((s & btn_q) == 4'b0000)) begin
      btn_nxt = prio_pick(s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 4'b0000;
    end else begin
      btn_q <= btn_nxt;
    end
  end

  assign bus.btn       = btn_q;
  assign bus.press_evt = rise;

endmodule
